tape_controller: RTL and testbench

Data-tape controller for the Brainfuck core. Sits between the instruction decoder and the data `ram`. It owns the data pointer and turns tape commands (`+ - < > , .` and the cell read used for `[`/`]` zero tests) into single-port RAM read/modify/write sequences. It returns the resulting cell value to the decoder on a one-cycle response strobe.

---
 rtl/tape_controller.sv | 180 ++++++++++++++++++
 tb/tb_tape_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tape_controller.sv
// -----------------------------------------------------------------------------
// tape_controller
//
// Data-tape controller for the Brainfuck core. It owns the data pointer and
// turns tape commands into read/modify/write sequences on a single-port RAM
// with a registered (1-cycle latency) read port. Each accepted command
// produces exactly one rsp_valid pulse carrying the resulting cell value.
//
// Optional feature macro: TAPE_WRAP_EN
//   defined   : LEFT/RIGHT wrap the pointer modulo 2**ADDR_WIDTH, no bound err
//   undefined : pointer saturates at the tape ends and err is set
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   cmd_valid/ready command handshake (accepted when both high at posedge)
//   cmd_op          0 INC, 1 DEC, 2 LEFT, 3 RIGHT, 4 PUT, 5 GET, 6-7 reserved
//   cmd_data        value for PUT
//   rsp_valid       one-cycle completion strobe
//   rsp_data        cell value after the command (valid with rsp_valid)
//   rsp_zero        rsp_data == 0 (valid with rsp_valid)
//   ptr             current data pointer
//   err             sticky error (reserved op, or bound hit without wrap)
//   ram_en/ram_wen  RAM enable / write enable
//   ram_addr        RAM address, always equal to ptr
//   ram_write       RAM write data (zero outside the write cycle)
//   ram_read        RAM registered read data
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tape_controller #(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_zero,
    output logic [ADDR_WIDTH-1:0] ptr,
    output logic                  err,
    output logic                  ram_en,
    output logic                  ram_wen,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_write,
    input  logic [DATA_WIDTH-1:0] ram_read
);

    localparam logic [2:0] OP_INC   = 3'd0;
    localparam logic [2:0] OP_DEC   = 3'd1;
    localparam logic [2:0] OP_LEFT  = 3'd2;
    localparam logic [2:0] OP_RIGHT = 3'd3;
    localparam logic [2:0] OP_PUT   = 3'd4;
    localparam logic [2:0] OP_GET   = 3'd5;

    localparam logic [DATA_WIDTH-1:0] ONE_D   = DATA_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic                    err_q, err_d;
    logic [2:0]              op_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    accept;

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign ptr       = ptr_q;
    assign ram_addr  = ptr_q;
    assign err       = err_q;
    assign rsp_zero  = rsp_valid && (rsp_data == '0);

    // Control state: aborted immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    // Captured command; only meaningful while the FSM is busy, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        err_d     = err_q;
        ram_en    = 1'b0;
        ram_wen   = 1'b0;
        ram_write = '0;
        rsp_valid = 1'b0;
        rsp_data  = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RD;
                    case (cmd_op)
                        OP_INC, OP_DEC, OP_GET: ;
                        OP_PUT: state_d = WR;
                        // Pointer moves at the accept edge so RD fetches the
                        // new cell and ram_addr stays stable during RD.
                        OP_LEFT: begin
`ifdef TAPE_WRAP_EN
                            ptr_d = ptr_q - ONE_A;
`else
                            if (ptr_q == '0) err_d = 1'b1;
                            else             ptr_d = ptr_q - ONE_A;
`endif
                        end
                        OP_RIGHT: begin
`ifdef TAPE_WRAP_EN
                            ptr_d = ptr_q + ONE_A;
`else
                            if (ptr_q == PTR_MAX) err_d = 1'b1;
                            else                  ptr_d = ptr_q + ONE_A;
`endif
                        end
                        // Reserved opcodes flag the error and act as GET.
                        default: err_d = 1'b1;
                    endcase
                end
            end

            RD: begin
                ram_en  = 1'b1;
                state_d = ((op_q == OP_INC) || (op_q == OP_DEC)) ? WR : DONE;
            end

            WR: begin
                ram_en  = 1'b1;
                ram_wen = 1'b1;
                if (op_q == OP_INC)      ram_write = ram_read + ONE_D;
                else if (op_q == OP_DEC) ram_write = ram_read - ONE_D;
                else                     ram_write = data_q;
                rsp_valid = 1'b1;
                rsp_data  = ram_write;
                state_d   = IDLE;
            end

            DONE: begin
                // ram_read still holds the value fetched during RD.
                rsp_valid = 1'b1;
                rsp_data  = ram_read;
                state_d   = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tape_controller.sv
`timescale 1ns/1ps

module tb_tape_controller;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int CELLS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_zero;
    logic [AW-1:0] ptr;
    logic          err;
    logic          ram_en;
    logic          ram_wen;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_write;
    logic [DW-1:0] ram_read;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tape_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
        .ptr(ptr), .err(err),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_write(ram_write), .ram_read(ram_read)
    );

    // Single-port RAM, registered read-first output; never reset.
    logic [DW-1:0] mem [CELLS];
    always @(posedge clk) begin
        if (ram_en) begin
            ram_read <= mem[ram_addr];
            if (ram_wen) mem[ram_addr] <= ram_write;
        end
    end

    // Reference model: the tape as an array, a pointer and a sticky flag.
    logic [DW-1:0] tape [CELLS];
    int            m_ptr;
    bit            m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Apply one command to the model; returns expected response value and
    // the number of cycles from accept to rsp_valid.
    task automatic model(input logic [2:0] op, input logic [DW-1:0] d,
                         output logic [DW-1:0] expd, output int lat);
        lat = 2;
        case (op)
            3'd0: tape[m_ptr] = tape[m_ptr] + 8'd1;
            3'd1: tape[m_ptr] = tape[m_ptr] - 8'd1;
            3'd2: begin
`ifdef TAPE_WRAP_EN
                m_ptr = (m_ptr + CELLS - 1) % CELLS;
`else
                if (m_ptr == 0) m_err = 1; else m_ptr = m_ptr - 1;
`endif
            end
            3'd3: begin
`ifdef TAPE_WRAP_EN
                m_ptr = (m_ptr + 1) % CELLS;
`else
                if (m_ptr == CELLS - 1) m_err = 1; else m_ptr = m_ptr + 1;
`endif
            end
            3'd4: begin tape[m_ptr] = d; lat = 1; end
            3'd5: ;
            default: m_err = 1;
        endcase
        expd = tape[m_ptr];
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [DW-1:0] d);
        logic [DW-1:0] expd;
        int lat;
        int waited;
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("ready_wait", {31'd0, cmd_ready}, 32'd1);
        model(op, d, expd, lat);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(posedge clk);
        #1;
        // Keep valid asserted with junk while busy: it must be ignored.
        cmd_op   = 3'($urandom);
        cmd_data = 8'($urandom);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k <= lat) check("busy_ready", {31'd0, cmd_ready}, 32'd0);
            else          check("ready_back", {31'd0, cmd_ready}, 32'd1);
            check("rsp_valid", {31'd0, rsp_valid}, {31'd0, (k == lat)});
            if (k == lat) begin
                check("rsp_data", {24'd0, rsp_data}, {24'd0, expd});
                check("rsp_zero", {31'd0, rsp_zero}, {31'd0, (expd == 8'd0)});
                check("ptr", {28'd0, ptr}, 32'(m_ptr));
                check("ram_addr", {28'd0, ram_addr}, 32'(m_ptr));
                check("err", {31'd0, err}, {31'd0, m_err});
                cmd_valid = 1'b0;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {6'd0, cmd_ready, rsp_valid, rsp_zero, ram_en, ram_wen, err,
                    ptr, rsp_data, ram_write}, 32'd0);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_pulse");
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
        m_err = 0;
    endtask

    initial begin
        logic [2:0] rop;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = '0;
        m_ptr     = 0;
        m_err     = 0;
        for (int i = 0; i < CELLS; i++) begin
            mem[i]  = '0;
            tape[i] = '0;
        end
        #2;
        check_reset_outputs("reset_vals");
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_hold");
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

        // PUT and wrapping INC/DEC
        do_cmd(3'd4, 8'h41);
        do_cmd(3'd4, 8'hFF);
        do_cmd(3'd0, 8'h00);
        do_cmd(3'd1, 8'h00);

        // Moving between cells
        do_cmd(3'd4, 8'h05);
        do_cmd(3'd3, 8'h00);
        do_cmd(3'd4, 8'h07);
        do_cmd(3'd2, 8'h00);
        do_cmd(3'd3, 8'h00);

        // Lower bound, then upper bound
        do_cmd(3'd2, 8'h00);
        do_cmd(3'd2, 8'h00);
        rst_pulse();
        for (int i = 0; i < CELLS; i++) do_cmd(3'd3, 8'h00);

        // Reserved opcode: GET-like response, sticky err
        rst_pulse();
        do_cmd(3'd6, 8'h99);
        do_cmd(3'd4, 8'h00);
        do_cmd(3'd5, 8'h00);
        do_cmd(3'd7, 8'h12);

        // Randomized command stream
        for (int i = 0; i < 300; i++) begin
            rop = (($urandom % 40) == 0) ? 3'(6 + ($urandom % 2)) : 3'($urandom % 6);
            do_cmd(rop, 8'($urandom));
        end

        // Reset during the RD cycle of an INC aborts without writing
        rst_pulse();
        do_cmd(3'd4, 8'h10);
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rd_cycle_en", {30'd0, ram_en, ram_wen}, 32'd2);
        rst = 1'b1;
        #1;
        check_reset_outputs("abort_rst");
        @(negedge clk);
        check_reset_outputs("abort_rst_hold");
        rst   = 1'b0;
        m_ptr = 0;
        m_err = 0;
        #1;
        check("ready_after_abort", {31'd0, cmd_ready}, 32'd1);
        do_cmd(3'd5, 8'h00);
        check("abort_no_write", {24'd0, mem[0]}, 32'h10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
